// File: rtl/dffram_pkg.sv
// rtl/dffram_pkg.sv - shared constants and helpers for the DFF RAM arbiter
package dffram_pkg;
  localparam int AW     = 5;
  localparam int DW     = 8;
  localparam int WORDS  = 2**AW;
  localparam int MAXREQ = 8;

  // Index of the set bit in a one-hot vector (zero when the vector is empty)
  function automatic logic [2:0] rr_onehot2idx(input logic [MAXREQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAXREQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/dffram_rr_pick.sv
// rtl/dffram_rr_pick.sv - rotating-priority finder over an N-wide mask
module dffram_rr_pick
  import dffram_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [MAXREQ-1:0] onehot;
  logic [2:0]        sel;
  int                j;

  // Scan downward in priority so the candidate closest to start overwrites the rest
  always_comb begin
    onehot = '0;
    j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(start) + k) % N;
      if (mask[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
      end
    end
  end

  assign sel   = rr_onehot2idx(onehot);
  assign idx   = sel[IW-1:0];
  assign found = |mask;
endmodule

// File: rtl/dffram_2r1w_arbiter.sv
// rtl/dffram_2r1w_arbiter.sv - round-robin sharing of a 2R1W DFF RAM among NREQ requesters
module dffram_2r1w_arbiter
  import dffram_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = dffram_pkg::AW,
  parameter int DW   = dffram_pkg::DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr_a,
  output logic [DW-1:0]     ram_wdata_a,
  output logic [AW-1:0]     ram_addr_b,
  input  logic [DW-1:0]     ram_rdata_a,
  input  logic [DW-1:0]     ram_rdata_b
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   ptr;
  logic            a_found, b_found;
  logic [IW-1:0]   ga, gb, b_start, last;
  logic [NREQ-1:0] a_oh, b_oh, b_mask;
  logic            fwd;

  dffram_rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
    .mask (req_valid),
    .start(ptr),
    .found(a_found),
    .idx  (ga)
  );

  // Port B only reads, and must not pick the requester already holding port A
  assign a_oh    = a_found ? (NREQ'(1) << ga) : '0;
  assign b_mask  = req_valid & ~req_we & ~a_oh;
  assign b_start = (ga == IW'(NREQ - 1)) ? '0 : ga + IW'(1);

  dffram_rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
    .mask (b_mask),
    .start(b_start),
    .found(b_found),
    .idx  (gb)
  );

  assign b_oh      = b_found ? (NREQ'(1) << gb) : '0;
  assign req_ready = rst ? '0 : (a_oh | b_oh);

  assign ram_we      = a_found & req_we[ga];
  assign ram_addr_a  = a_found ? req_addr[ga*AW +: AW] : '0;
  assign ram_wdata_a = a_found ? req_wdata[ga*DW +: DW] : '0;
  assign ram_addr_b  = b_found ? req_addr[gb*AW +: AW] : '0;

  // RAM returns pre-write contents, so a port B read of the word being written takes the new data
  assign fwd  = ram_we & b_found & (ram_addr_a == ram_addr_b);
  assign last = b_found ? gb : ga;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      if (a_found) ptr <= (last == IW'(NREQ - 1)) ? '0 : last + IW'(1);
      rsp_valid <= req_ready & req_valid;
      for (int i = 0; i < NREQ; i++) begin
        if (a_oh[i])
          rsp_rdata[i*DW +: DW] <= req_we[i] ? req_wdata[i*DW +: DW] : ram_rdata_a;
        else if (b_oh[i])
          rsp_rdata[i*DW +: DW] <= fwd ? ram_wdata_a : ram_rdata_b;
      end
    end
  end
endmodule
